// File: rtl/frame_buf.sv
// Double-buffered 64x32 RGB444 frame store feeding the HUB75 controller.
// Front buffer is read by the display; the renderer writes, clears and swaps the back buffer.
module frame_buf #(
    parameter logic [11:0] CLR_COLOR  = 12'h000,
    parameter bit          INIT_FRONT = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  r_addr,
    output logic [11:0] din_top,
    output logic [11:0] din_btm,
    input  logic        wr_en,
    input  logic [5:0]  wr_x,
    input  logic [4:0]  wr_y,
    input  logic [11:0] wr_data,
    output logic        wr_ready,
    input  logic        clr_req,
    input  logic        swap_req,
    output logic        busy,
    output logic        swap_done,
    output logic        front_sel
);

    typedef enum logic [1:0] {StIdle, StClear, StSwapWait} state_e;

    state_e      state;
    logic [11:0] mem [4096];
    logic [10:0] cnt;
    logic        swap_pend;
    logic        swap_fire;
    logic [9:0]  prev_addr;
    logic        fb;
    logic        mem_we;
    logic [11:0] mem_waddr;
    logic [11:0] mem_wdata;

    assign wr_ready = (state == StIdle);
    assign busy     = (state != StIdle);
    assign fb       = (prev_addr == 10'd1023) && (r_addr == 10'd0);

    // Clear and renderer writes never overlap: renderer writes are only taken in StIdle.
    // A synchronous reset blocks the write so an aborted clear stops exactly where it was.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = {~front_sel, wr_y, wr_x};
        mem_wdata = wr_data;
        if (!rst) begin
            if (state == StClear) begin
                mem_we    = 1'b1;
                mem_waddr = {~front_sel, cnt};
                mem_wdata = CLR_COLOR;
            end else if (wr_en && wr_ready) begin
                mem_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            din_top <= 12'h000;
            din_btm <= 12'h000;
        end else begin
            din_top <= mem[{front_sel, 1'b0, r_addr}];
            din_btm <= mem[{front_sel, 1'b1, r_addr}];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            front_sel <= INIT_FRONT;
            swap_pend <= 1'b0;
            cnt       <= 11'd0;
            swap_fire <= 1'b0;
            swap_done <= 1'b0;
            prev_addr <= 10'd0;
        end else begin
            prev_addr <= r_addr;
            swap_fire <= 1'b0;
            swap_done <= swap_fire;
            case (state)
                StIdle: begin
                    if (clr_req) begin
                        state     <= StClear;
                        cnt       <= 11'd0;
                        swap_pend <= swap_req;
                    end else if (swap_req) begin
                        state <= StSwapWait;
                    end
                end
                StClear: begin
                    cnt <= cnt + 11'd1;
                    if (swap_req) begin
                        swap_pend <= 1'b1;
                    end
                    if (cnt == 11'd2047) begin
                        // A swap requested on the final clear cycle is still honoured.
                        swap_pend <= 1'b0;
                        state     <= (swap_pend || swap_req) ? StSwapWait : StIdle;
                    end
                end
                StSwapWait: begin
                    if (fb) begin
                        front_sel <= ~front_sel;
                        swap_fire <= 1'b1;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_buf.sv
// Self-checking bench for frame_buf: reference pixel store plus a read scoreboard.
// Reads push their expected pixel pair and are compared one cycle later.
module tb_frame_buf;

    localparam logic [11:0] CLR = 12'h5A3;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  r_addr;
    logic [11:0] din_top;
    logic [11:0] din_btm;
    logic        wr_en;
    logic [5:0]  wr_x;
    logic [4:0]  wr_y;
    logic [11:0] wr_data;
    logic        wr_ready;
    logic        clr_req;
    logic        swap_req;
    logic        busy;
    logic        swap_done;
    logic        front_sel;

    frame_buf #(.CLR_COLOR(CLR), .INIT_FRONT(1'b0)) dut (
        .clk      (clk),
        .rst      (rst),
        .r_addr   (r_addr),
        .din_top  (din_top),
        .din_btm  (din_btm),
        .wr_en    (wr_en),
        .wr_x     (wr_x),
        .wr_y     (wr_y),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .clr_req  (clr_req),
        .swap_req (swap_req),
        .busy     (busy),
        .swap_done(swap_done),
        .front_sel(front_sel)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  addr;
        logic [11:0] top;
        logic [11:0] btm;
        bit          ct;
        bit          cb;
    } rd_t;

    rd_t         sb[$];
    logic [11:0] ref_mem [4096];
    bit          ref_known [4096];
    bit          exp_front;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_at(input logic [9:0] a);
        rd_t e;
        rd_t g;
        e.addr = a;
        e.top  = ref_mem[{exp_front, 1'b0, a}];
        e.btm  = ref_mem[{exp_front, 1'b1, a}];
        e.ct   = ref_known[{exp_front, 1'b0, a}];
        e.cb   = ref_known[{exp_front, 1'b1, a}];
        sb.push_back(e);
        r_addr = a;
        tick();
        g = sb.pop_front();
        if (g.ct) begin
            vectors++;
            if (din_top !== g.top) begin
                miscompares++;
                $display("FAIL rd_top addr=%h got %h want %h", g.addr, din_top, g.top);
            end
        end
        if (g.cb) begin
            vectors++;
            if (din_btm !== g.btm) begin
                miscompares++;
                $display("FAIL rd_btm addr=%h got %h want %h", g.addr, din_btm, g.btm);
            end
        end
    endtask

    task automatic write_px(input logic [5:0] x, input logic [4:0] y, input logic [11:0] d,
                            input bit accept);
        wr_en = 1'b1;
        wr_x = x;
        wr_y = y;
        wr_data = d;
        vectors++;
        if (wr_ready !== accept) begin
            miscompares++;
            $display("FAIL wr_ready x=%0d y=%0d got %b want %b", x, y, wr_ready, accept);
        end
        tick();
        wr_en = 1'b0;
        if (accept) begin
            ref_mem[{~exp_front, y, x}] = d;
            ref_known[{~exp_front, y, x}] = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; r_addr = '0; wr_en = 1'b0; wr_x = '0; wr_y = '0; wr_data = '0;
        clr_req = 1'b0; swap_req = 1'b0;
        repeat (3) tick();
        exp_front = 1'b0;
        vectors++;
        if (front_sel !== 1'b0 || busy !== 1'b0 || wr_ready !== 1'b1 || swap_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl got fs=%b busy=%b rdy=%b sd=%b want 0 0 1 0",
                     front_sel, busy, wr_ready, swap_done);
        end
        vectors++;
        if (din_top !== 12'h000 || din_btm !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_din got %h/%h want 000/000", din_top, din_btm);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_clear_swap();
        int n;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 3000) begin
            tick();
            n++;
        end
        vectors++;
        if (n != 2048) begin
            miscompares++;
            $display("FAIL clear_len got %0d busy cycles want 2048", n);
        end
        for (int i = 0; i < 2048; i++) begin
            ref_mem[{~exp_front, i[10:0]}] = CLR;
            ref_known[{~exp_front, i[10:0]}] = 1'b1;
        end
        swap_req = 1'b1;
        r_addr = 10'd0;
        tick();
        swap_req = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL swap_busy got %b want 1", busy);
        end
        for (int a = 1; a < 1024; a++) read_at(a[9:0]);
        vectors++;
        if (front_sel !== exp_front) begin
            miscompares++;
            $display("FAIL early_swap front_sel got %b want %b", front_sel, exp_front);
        end
        read_at(10'd0);
        exp_front = ~exp_front;
        vectors++;
        if (front_sel !== exp_front || swap_done !== 1'b0) begin
            miscompares++;
            $display("FAIL swap_edge got fs=%b sd=%b want %b 0", front_sel, swap_done, exp_front);
        end
        tick();
        vectors++;
        if (swap_done !== 1'b1) begin
            miscompares++;
            $display("FAIL swap_done_pulse got %b want 1", swap_done);
        end
        tick();
        vectors++;
        if (swap_done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL swap_after got sd=%b busy=%b want 0 0", swap_done, busy);
        end
        for (int a = 0; a < 1024; a++) read_at(a[9:0]);
    endtask

    task automatic test_write_swap();
        write_px(6'd5, 5'd3, 12'hF0A, 1'b1);
        write_px(6'd5, 5'd19, 12'h0B1, 1'b1);
        read_at({4'd3, 6'd5});
        swap_req = 1'b1;
        r_addr = 10'd0;
        tick();
        swap_req = 1'b0;
        read_at(10'd1023);
        read_at(10'd0);
        exp_front = ~exp_front;
        vectors++;
        if (front_sel !== exp_front) begin
            miscompares++;
            $display("FAIL ws_front got %b want %b", front_sel, exp_front);
        end
        tick();
        read_at({4'd3, 6'd5});
    endtask

    task automatic test_write_dropped();
        swap_req = 1'b1;
        r_addr = 10'd0;
        tick();
        swap_req = 1'b0;
        write_px(6'd7, 5'd2, 12'h123, 1'b0);
        read_at(10'd1023);
        read_at(10'd0);
        exp_front = ~exp_front;
        tick();
        read_at({4'd2, 6'd7});
    endtask

    task automatic test_clr_swap_same();
        int n;
        int pulses;
        clr_req = 1'b1;
        swap_req = 1'b1;
        r_addr = 10'd0;
        tick();
        clr_req = 1'b0;
        swap_req = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 2100) begin
            clr_req = (n == 2070);
            tick();
            n++;
        end
        clr_req = 1'b0;
        vectors++;
        if (n != 2100) begin
            miscompares++;
            $display("FAIL cs_busy busy dropped after %0d cycles want >=2100", n);
        end
        for (int i = 0; i < 2048; i++) begin
            ref_mem[{~exp_front, i[10:0]}] = CLR;
            ref_known[{~exp_front, i[10:0]}] = 1'b1;
        end
        read_at(10'd1023);
        read_at(10'd0);
        exp_front = ~exp_front;
        pulses = int'(swap_done);
        for (int i = 0; i < 4; i++) begin
            tick();
            pulses += int'(swap_done);
        end
        vectors++;
        if (pulses != 1 || front_sel !== exp_front || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL cs_swap got pulses=%0d fs=%b busy=%b want 1 %b 0",
                     pulses, front_sel, exp_front, busy);
        end
        read_at({4'd3, 6'd5});
    endtask

    task automatic test_no_boundary();
        swap_req = 1'b1;
        r_addr = 10'd0;
        tick();
        swap_req = 1'b0;
        repeat (40) tick();
        for (int a = 1; a < 1023; a++) read_at(a[9:0]);
        read_at(10'd0);
        repeat (5) tick();
        vectors++;
        if (busy !== 1'b1 || front_sel !== exp_front) begin
            miscompares++;
            $display("FAIL nb_hold got busy=%b fs=%b want 1 %b", busy, front_sel, exp_front);
        end
        read_at(10'd1023);
        read_at(10'd0);
        exp_front = ~exp_front;
        tick();
        vectors++;
        if (busy !== 1'b0 || front_sel !== exp_front) begin
            miscompares++;
            $display("FAIL nb_swap got busy=%b fs=%b want 0 %b", busy, front_sel, exp_front);
        end
    endtask

    task automatic test_reset_mid_clear();
        bit old_back;
        old_back = ~exp_front;
        write_px(6'd0, 5'd0, 12'h666, 1'b1);
        write_px(6'd39, 5'd15, 12'h111, 1'b1);
        write_px(6'd40, 5'd15, 12'h222, 1'b1);
        write_px(6'd41, 5'd15, 12'h333, 1'b1);
        write_px(6'd63, 5'd15, 12'h444, 1'b1);
        write_px(6'd63, 5'd31, 12'h555, 1'b1);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (1000) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_front = 1'b0;
        vectors++;
        if (wr_ready !== 1'b1 || busy !== 1'b0 || front_sel !== 1'b0 || swap_done !== 1'b0) begin
            miscompares++;
            $display("FAIL rmc_ctrl got rdy=%b busy=%b fs=%b sd=%b want 1 0 0 0",
                     wr_ready, busy, front_sel, swap_done);
        end
        vectors++;
        if (din_top !== 12'h000 || din_btm !== 12'h000) begin
            miscompares++;
            $display("FAIL rmc_din got %h/%h want 000/000", din_top, din_btm);
        end
        for (int i = 0; i < 1000; i++) begin
            ref_mem[{old_back, i[10:0]}] = CLR;
            ref_known[{old_back, i[10:0]}] = 1'b1;
        end
        read_at({4'd15, 6'd39});
        read_at({4'd15, 6'd40});
        read_at({4'd15, 6'd41});
        read_at({4'd15, 6'd63});
        read_at(10'd0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            ref_mem[i] = 12'h000;
            ref_known[i] = 1'b0;
        end
        test_reset();
        test_clear_swap();
        test_write_swap();
        test_write_dropped();
        test_clr_swap_same();
        test_no_boundary();
        test_reset_mid_clear();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached vectors=%0d miscompares=%0d",
                 vectors, miscompares);
        $fatal(1, "watchdog");
    end

endmodule
